// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential multiplier and its ALU.
// Widths, FSM encoding, iteration count and ALU function codes.
`ifndef ALU_MUL_SEQ_PKG_SV
`define ALU_MUL_SEQ_PKG_SV
package alu_mul_seq_pkg;

  localparam int DATA_W     = 16;
  localparam int ALU_FUNC_W = 3;
  localparam int MUL_ITERS  = 16;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } mul_state_e;

  localparam logic [ALU_FUNC_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_FUNC_W-1:0] ALU_SLL = 3'd2;
  localparam logic [ALU_FUNC_W-1:0] ALU_SRL = 3'd3;
  localparam logic [ALU_FUNC_W-1:0] ALU_AND = 3'd4;
  localparam logic [ALU_FUNC_W-1:0] ALU_OR  = 3'd5;
  localparam logic [ALU_FUNC_W-1:0] ALU_XOR = 3'd6;

endpackage
`endif

// File: rtl/alu.sv
// Shared combinational ALU; instantiated beside alu_mul_seq.
// Results are truncated to DATA_W bits.
module alu
  import alu_mul_seq_pkg::*;
(
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  input  logic [ALU_FUNC_W-1:0] func,
  output logic [DATA_W-1:0]     y
);

  always_comb begin
    y = '0;
    case (func)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLL: y = a << b;
      ALU_SRL: y = a >> b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiplier reusing the shared ALU.
// Optional MUL_EARLY_EXIT_EN stops once the multiplier is exhausted.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [ALU_FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0]     alu_y
);

  mul_state_e state, state_nxt;

  logic [DATA_W-1:0] p_q;
  logic [DATA_W-1:0] m_q;
  logic [DATA_W-1:0] q_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] q_shr;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last;
  logic              zero_b;

  assign q_shr   = q_q >> 1;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef MUL_EARLY_EXIT_EN
  assign last   = (q_shr == '0);
  assign zero_b = (op_b == '0);
`else
  assign last   = (cnt_inc == CNT_W'(MUL_ITERS));
  assign zero_b = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (zero_b)       state_nxt = S_DONE;
          else if (op_b[0]) state_nxt = S_ADD;
          else              state_nxt = S_SHIFT;
        end
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (last)          state_nxt = S_DONE;
        else if (q_shr[0]) state_nxt = S_ADD;
        else               state_nxt = S_SHIFT;
      end
      S_DONE:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    alu_func = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    unique case (state)
      S_IDLE: ;
      S_ADD: begin
        busy  = 1'b1;
        alu_a = p_q;
        alu_b = m_q;
      end
      S_SHIFT: begin
        busy     = 1'b1;
        alu_func = ALU_SLL;
        alu_a    = m_q;
        alu_b    = DATA_W'(1);
      end
      S_DONE: done = 1'b1;
    endcase
  end

  // Datapath registers; ALU result is written back in ADD/SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      m_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      result <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            p_q   <= '0;
            m_q   <= op_a;
            q_q   <= op_b;
            cnt_q <= '0;
          end
        end
        S_ADD: p_q <= alu_y;
        S_SHIFT: begin
          m_q   <= alu_y;
          q_q   <= q_shr;
          cnt_q <= cnt_inc;
        end
        S_DONE: result <= p_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq wired to the shared alu.
// Default build (early exit disabled).
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     result;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [ALU_FUNC_W-1:0] alu_func;
  logic [DATA_W-1:0]     alu_y;

  int checks   = 0;
  int failures = 0;

  logic [ALU_FUNC_W-1:0] fq[$];

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_func (alu_func),
    .alu_y    (alu_y)
  );

  alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .func (alu_func),
    .y    (alu_y)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after done.
  task automatic run_mul(input string tag,
                         input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b,
                         input int exp_busy,
                         input logic [DATA_W-1:0] exp_res);
    int nb;
    bit got;
    nb  = 0;
    got = 1'b0;
    fq.delete();
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    for (int i = 0; i < 200 && !got; i++) begin
      if (busy) begin
        nb++;
        fq.push_back(alu_func);
      end
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int nb;
    int nd;
    int nsll;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);

    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_done",   32'(done),     32'd0);
    chk("rst_result", 32'(result),   32'd0);
    chk("rst_func",   32'(alu_func), 32'(ALU_ADD));
    chk("rst_alu_a",  32'(alu_a),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_mul("m3x5", 16'd3, 16'd5, 18, 16'h000F);
    chk("m3x5_nfunc", 32'(fq.size()), 32'd18);
    if (fq.size() >= 5) begin
      chk("m3x5_f0", 32'(fq[0]), 32'(ALU_ADD));
      chk("m3x5_f1", 32'(fq[1]), 32'(ALU_SLL));
      chk("m3x5_f2", 32'(fq[2]), 32'(ALU_SLL));
      chk("m3x5_f3", 32'(fq[3]), 32'(ALU_ADD));
      chk("m3x5_f4", 32'(fq[4]), 32'(ALU_SLL));
    end
    nsll = 0;
    foreach (fq[i]) if (fq[i] == ALU_SLL) nsll++;
    chk("m3x5_nsll", 32'(nsll), 32'd16);

    repeat (3) @(negedge clk);
    chk("hold_result", 32'(result), 32'h000F);
    chk("idle_alu_a",  32'(alu_a),  32'd0);
    chk("idle_alu_b",  32'(alu_b),  32'd0);

    run_mul("mffff", 16'hFFFF, 16'hFFFF, 32, 16'h0001);
    run_mul("m00ff", 16'h00FF, 16'h0101, 18, 16'hFFFF);
    run_mul("mzero", 16'h1234, 16'h0000, 16, 16'h0000);
    run_mul("m8000", 16'h0003, 16'h8000, 17, 16'h8000);

    // start while busy must be ignored
    start = 1'b1;
    op_a  = 16'd7;
    op_b  = 16'd9;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      if (done) nd++;
      start = busy && (nb == 2 || nb == 5);
      op_a  = 16'hFFFF;
      op_b  = 16'hFFFF;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_done_cnt", 32'(nd),     32'd1);
    chk("ign_busy",     32'(nb),     32'd18);
    chk("ign_result",   32'(result), 32'h003F);

    // reset in the middle of a multiply
    start = 1'b1;
    op_a  = 16'd7;
    op_b  = 16'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy4", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy",   32'(busy),     32'd0);
    chk("mrst_done",   32'(done),     32'd0);
    chk("mrst_result", 32'(result),   32'd0);
    chk("mrst_func",   32'(alu_func), 32'(ALU_ADD));
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    chk("mrst_quiet", 32'(nd), 32'd0);

    run_mul("m2x3", 16'd2, 16'd3, 18, 16'h0006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
